// File: rtl/dram_slink_bringup_seq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dram_slink_bringup_seq_pkg
// Brief    : Shared types and default register map for the serial-link
//            bring-up sequencer (also the source for boot ROM headers).
// Revision : 1.0 - initial release
// ============================================================================
package dram_slink_bringup_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_DIV  = 3'd1,
        ST_WR_HOLD = 3'd2,
        ST_WR_RUN  = 3'd3,
        ST_GAP     = 3'd4,
        ST_RD_STAT = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERR     = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BUS     = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_code_e;

    localparam logic [47:0] c_base_addr      = 48'h0;
    localparam logic [47:0] c_ctrl_offset    = 48'h0;
    localparam logic [47:0] c_clkdiv_offset  = 48'h10;
    localparam logic [47:0] c_status_offset  = 48'h4;
    localparam logic [31:0] c_ctrl_hold_val  = 32'h0000_0301;
    localparam logic [31:0] c_ctrl_run_val   = 32'h0000_0003;
    localparam logic [31:0] c_isolated_mask  = 32'h0000_0300;

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dram_slink_bringup_seq_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dram_slink_bringup_seq_if
// Brief    : Register-bus request/response bundle for the serial-link cfg port.
// Revision : 1.0 - initial release
// ============================================================================
interface dram_slink_bringup_seq_if #(
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned DataWidth = 32
);
    logic                   valid;
    logic                   write;
    logic [AddrWidth-1:0]   addr;
    logic [DataWidth-1:0]   wdata;
    logic [DataWidth/8-1:0] wstrb;
    logic                   ready;
    logic [DataWidth-1:0]   rdata;
    logic                   error;

    modport master (
        output valid, write, addr, wdata, wstrb,
        input  ready, rdata, error
    );

    modport slave (
        input  valid, write, addr, wdata, wstrb,
        output ready, rdata, error
    );
endinterface
`default_nettype wire

// File: rtl/dram_slink_bringup_seq_reg_master_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dram_slink_bringup_seq_reg_master_port
// Brief    : Single-outstanding reg-bus request holder; fields stay stable
//            from valid rise until the ready cycle.
// Revision : 1.0 - initial release
// ============================================================================
module dram_slink_bringup_seq_reg_master_port #(
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned DataWidth = 32
) (
    input  wire logic                 clk_i,
    input  wire logic                 rst_ni,
    input  wire logic                 i_issue,
    input  wire logic                 i_write,
    input  wire logic [AddrWidth-1:0] i_addr,
    input  wire logic [DataWidth-1:0] i_wdata,
    output logic                      o_idle,
    output logic                      o_complete,
    output logic [DataWidth-1:0]      o_rdata,
    output logic                      o_error,
    dram_slink_bringup_seq_if.master  bus
);

    logic                 r_valid;
    logic                 r_write;
    logic [AddrWidth-1:0] r_addr;
    logic [DataWidth-1:0] r_wdata;

    // A new request is only taken while idle, so the cycle after a
    // completion is always idle on the bus.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (r_valid) begin
            if (bus.ready) begin
                r_valid <= 1'b0;
            end
        end else if (i_issue) begin
            r_valid <= 1'b1;
            r_write <= i_write;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
        end
    end

    assign bus.valid  = r_valid;
    assign bus.write  = r_write;
    assign bus.addr   = r_addr;
    assign bus.wdata  = r_wdata;
    assign bus.wstrb  = '1;

    assign o_idle     = !r_valid;
    assign o_complete = r_valid && bus.ready;
    assign o_rdata    = bus.rdata;
    assign o_error    = bus.error;

endmodule
`default_nettype wire

// File: rtl/dram_slink_bringup_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dram_slink_bringup_seq
// Brief    : DRAM serial-link bring-up sequencer with poll timeout, bounded
//            retry and sticky done/error status.
// Revision : 1.0 - initial release
// ============================================================================
module dram_slink_bringup_seq
    import dram_slink_bringup_seq_pkg::*;
#(
    parameter int unsigned          AddrWidth     = 48,
    parameter int unsigned          DataWidth     = 32,
    parameter logic [AddrWidth-1:0] BaseAddr      = AddrWidth'(c_base_addr),
    parameter logic [AddrWidth-1:0] CtrlOffset    = AddrWidth'(c_ctrl_offset),
    parameter logic [AddrWidth-1:0] ClkDivOffset  = AddrWidth'(c_clkdiv_offset),
    parameter logic [AddrWidth-1:0] StatusOffset  = AddrWidth'(c_status_offset),
    parameter int unsigned          ClkDiv        = 8,
    parameter logic [DataWidth-1:0] CtrlHoldVal   = DataWidth'(c_ctrl_hold_val),
    parameter logic [DataWidth-1:0] CtrlRunVal    = DataWidth'(c_ctrl_run_val),
    parameter logic [DataWidth-1:0] IsolatedMask  = DataWidth'(c_isolated_mask),
    parameter int unsigned          PollGap       = 4,
    parameter int unsigned          TimeoutCycles = 1024,
    parameter int unsigned          MaxRetries    = 3
) (
    input  wire logic                clk_i,
    input  wire logic                rst_ni,
    input  wire logic                start_i,
    dram_slink_bringup_seq_if.master reg_bus,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_o,
    output logic [1:0]               err_code_o,
    output logic [1:0]               attempts_o
);

    localparam int unsigned c_tmo_w = $clog2(TimeoutCycles + 1);
    localparam int unsigned c_gap_w = $clog2(PollGap + 1);
    localparam int unsigned c_rty_w = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;

    localparam logic [AddrWidth-1:0] c_addr_div  = BaseAddr + ClkDivOffset;
    localparam logic [AddrWidth-1:0] c_addr_ctrl = BaseAddr + CtrlOffset;
    localparam logic [AddrWidth-1:0] c_addr_stat = BaseAddr + StatusOffset;
    localparam logic [c_tmo_w-1:0]   c_tmo_last  = c_tmo_w'(TimeoutCycles - 1);
    localparam logic [c_gap_w-1:0]   c_gap_last  = c_gap_w'(PollGap - 1);
    localparam logic [c_rty_w-1:0]   c_rty_max   = c_rty_w'(MaxRetries);

    state_e               r_state;
    err_code_e            r_err_code;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;
    logic [1:0]           r_attempts;
    logic                 r_issued;
    logic [c_tmo_w-1:0]   r_tmo;
    logic [c_gap_w-1:0]   r_gap;
    logic [c_rty_w-1:0]   r_retry;

    logic                 w_req_state;
    logic                 w_req_write;
    logic [AddrWidth-1:0] w_req_addr;
    logic [DataWidth-1:0] w_req_data;
    logic                 w_issue;
    logic                 w_idle;
    logic                 w_complete;
    logic [DataWidth-1:0] w_rdata;
    logic                 w_bus_err;
    logic                 w_done;
    logic                 w_pass;
    logic                 w_expire;

    always_comb begin
        w_req_write = 1'b1;
        w_req_addr  = c_addr_div;
        w_req_data  = DataWidth'(ClkDiv);
        case (r_state)
            ST_WR_HOLD: begin
                w_req_addr = c_addr_ctrl;
                w_req_data = CtrlHoldVal;
            end
            ST_WR_RUN: begin
                w_req_addr = c_addr_ctrl;
                w_req_data = CtrlRunVal;
            end
            ST_RD_STAT: begin
                w_req_write = 1'b0;
                w_req_addr  = c_addr_stat;
                w_req_data  = '0;
            end
            default: ;
        endcase
    end

    assign w_req_state = (r_state == ST_WR_DIV) || (r_state == ST_WR_HOLD) ||
                         (r_state == ST_WR_RUN) || (r_state == ST_RD_STAT);
    // A read abandoned on timeout may still be in flight; r_issued keeps its
    // late completion from being taken as the current state's transfer.
    assign w_issue  = w_req_state && !r_issued && w_idle;
    assign w_done   = w_complete && r_issued;
    assign w_pass   = ((w_rdata & IsolatedMask) == '0);
    assign w_expire = ((r_state == ST_GAP) || (r_state == ST_RD_STAT)) &&
                      (r_tmo >= c_tmo_last);

    dram_slink_bringup_seq_reg_master_port #(
        .AddrWidth (AddrWidth),
        .DataWidth (DataWidth)
    ) u_port (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_issue    (w_issue),
        .i_write    (w_req_write),
        .i_addr     (w_req_addr),
        .i_wdata    (w_req_data),
        .o_idle     (w_idle),
        .o_complete (w_complete),
        .o_rdata    (w_rdata),
        .o_error    (w_bus_err),
        .bus        (reg_bus)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_err_code <= ERR_NONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_attempts <= 2'd0;
            r_issued   <= 1'b0;
            r_tmo      <= '0;
            r_gap      <= '0;
            r_retry    <= '0;
        end else begin
            if (w_issue) begin
                r_issued <= 1'b1;
            end
            if ((r_state == ST_GAP) || (r_state == ST_RD_STAT)) begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (w_complete && w_bus_err) begin
                r_state    <= ST_ERR;
                r_err_code <= ERR_BUS;
                r_error    <= 1'b1;
                r_busy     <= 1'b0;
                r_issued   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE, ST_ERR: begin
                        if (start_i) begin
                            r_state    <= ST_WR_DIV;
                            r_busy     <= 1'b1;
                            r_done     <= 1'b0;
                            r_error    <= 1'b0;
                            r_err_code <= ERR_NONE;
                            r_attempts <= 2'd0;
                            r_retry    <= '0;
                            r_issued   <= 1'b0;
                        end
                    end
                    ST_WR_DIV: begin
                        if (w_done) begin
                            r_state  <= ST_WR_HOLD;
                            r_issued <= 1'b0;
                        end
                    end
                    ST_WR_HOLD: begin
                        if (w_done) begin
                            r_state    <= ST_WR_RUN;
                            r_attempts <= sat_inc2(r_attempts);
                            r_issued   <= 1'b0;
                        end
                    end
                    ST_WR_RUN: begin
                        if (w_done) begin
                            r_state  <= ST_GAP;
                            r_tmo    <= '0;
                            r_gap    <= '0;
                            r_issued <= 1'b0;
                        end
                    end
                    ST_GAP, ST_RD_STAT: begin
                        // A passing status wins over a simultaneous expiry.
                        if ((r_state == ST_RD_STAT) && w_done && w_pass) begin
                            r_state  <= ST_DONE;
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                            r_issued <= 1'b0;
                        end else if (w_expire) begin
                            r_issued <= 1'b0;
                            if (r_retry < c_rty_max) begin
                                r_state <= ST_WR_HOLD;
                                r_retry <= r_retry + 1'b1;
                            end else begin
                                r_state    <= ST_ERR;
                                r_err_code <= ERR_TIMEOUT;
                                r_error    <= 1'b1;
                                r_busy     <= 1'b0;
                            end
                        end else if (r_state == ST_RD_STAT) begin
                            if (w_done) begin
                                r_state  <= ST_GAP;
                                r_gap    <= '0;
                                r_issued <= 1'b0;
                            end
                        end else if (r_gap == c_gap_last) begin
                            r_state  <= ST_RD_STAT;
                            r_issued <= 1'b0;
                        end else begin
                            r_gap <= r_gap + 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign error_o    = r_error;
    assign err_code_o = r_err_code;
    assign attempts_o = r_attempts;

endmodule
`default_nettype wire
